sdram_selftest_ctrl: RTL
========================

# sdram_selftest_ctrl

Self-test master on the user side of the SDRAM base module. On a start pulse it writes a deterministic 64-bit pattern to a configurable run of SDRAM words, reads them back, compares each against the regenerated pattern, and reports pass/fail, error count, first failing address and timeout. It drives the base module's call/done handshake directly: write call on bit 1, read call on bit 0.

## Interface
- `ADDR_START`, 24'h000000: first word address; {bank[1:0], row[12:0], col[8:0]}.
- `WORD_COUNT`, 256: number of 64-bit words tested (1..65535).
- `ADDR_STEP`, 4: address increment per word (one 64-bit word = 4 columns).
- `TIMEOUT`, 4096: maximum cycles a call may stay high without its done pulse.
- `CLOCK` in 1: sole clock; all logic on rising edge.
- `RESET` in 1: synchronous, active-high.
- `iStart` in 1: one-cycle start request.
- `oBusy` out 1: test in progress.
- `oPass` out 1: test finished, zero errors, no timeout.
- `oFail` out 1: test finished with errors or timeout.
- `oTimeout` out 1: last test aborted on timeout.
- `oErrCount` out 16: mismatching words, saturates at 16'hFFFF.
- `oFirstErrAddr` out 24: address of first mismatch; 0 if none.
- `oCall` out 2: to base module; [1] write, [0] read.
- `iDone` in 2: from base module; one-cycle done pulses, same bit mapping.
- `oAddr` out 24: word address to base module.
- `oData` out 64: write data to base module.
- `iData` in 64: read data from base module.

## Operation
- States: IDLE, WRITE, WR_NEXT, RD_INIT, READ, CHECK, FINISH.
- IDLE/FINISH + `iStart`: clear error count, first-error address, `oTimeout`, `oPass`, `oFail`; set addr=`ADDR_START`, index=0, load pattern; go WRITE. `iStart` ignored in all other states.
- WRITE: `oCall`=2'b10, `oAddr`=addr, `oData`=pattern. On `iDone[1]`: go WR_NEXT.
- WR_NEXT: `oCall`=0; advance addr (+`ADDR_STEP`, mod 2^24), index, pattern. If index was `WORD_COUNT`-1: go RD_INIT, else WRITE.
- RD_INIT: addr=`ADDR_START`, index=0, reload pattern; go READ.
- READ: `oCall`=2'b01, `oAddr`=addr. On `iDone[0]`: register `iData`; go CHECK.
- CHECK: `oCall`=0. Compare registered data with pattern. On mismatch: increment error count (saturating); if first mismatch, capture addr. Advance as in WR_NEXT. Last index: go FINISH, else READ.
- FINISH: `oBusy`=0. `oPass`=(errors==0 && !timeout), `oFail`=!`oPass`. Hold until next `iStart`.
- Default pattern: {8'hA5, addr, 8'h5A, ~addr}.
- `iDone` bit not matching the active call is ignored. `iDone` outside WRITE/READ is ignored.
- Timeout: a cycle counter clears on entering WRITE/READ and counts while there. When the count reaches `TIMEOUT`: set `oTimeout`, drop `oCall` to 0, and go to FINISH. `oFail`=1.

## Timing
- Reset values: state IDLE. `oCall`=0, `oAddr`=0, `oData`=0, `oBusy`=0, `oPass`=0, `oFail`=0, `oTimeout`=0, `oErrCount`=0, `oFirstErrAddr`=0.
- All outputs are registered.
- `oCall` rises on the cycle after `iStart` is sampled. It stays high through the cycle `iDone` is sampled and is low the next cycle.
- `oCall` is low for at least one cycle between consecutive transactions.
- `oAddr` and `oData` are stable for the entire time `oCall` is high.
- `oBusy` is high from the cycle after `iStart` until the FINISH entry cycle. `oPass`/`oFail` are valid in the same cycle `oBusy` falls.
- Zero-latency done (`iDone` sampled on the first call cycle): per-word cost is 2 cycles write, 2 cycles read.
- `RESET` mid-test: everything returns to reset values next cycle and `oCall` drops immediately; the in-flight SDRAM access is abandoned.
- Timeout and `iDone` sampled in the same cycle: `iDone` wins, the transaction completes normally.

## Configuration
- `SDRAM_SELFTEST_LFSR_EN` defined: the pattern is a 64-bit Fibonacci LFSR (taps 64,63,61,60) seeded with 64'h0123_4567_89AB_CDEF at start and at RD_INIT. It advances once per word, so the read phase replays the write sequence.
- Not defined: the address-derived pattern above; no LFSR logic is built.

## Test plan
- `WORD_COUNT`=4, ideal responder (done 3 cycles after call): writes go to 0x000000/04/08/0C with {A5,addr,5A,~addr}; readback matches; `oPass`=1, `oErrCount`=0.
- Responder corrupts bit 0 of the read at 0x000008: `oFail`=1, `oErrCount`=1, `oFirstErrAddr`=24'h000008.
- Responder never returns `iDone[0]`, `TIMEOUT`=16: `oCall` falls 16 cycles after the read call rises; `oTimeout`=1, `oFail`=1.
- `ADDR_START`=24'hFFFFFC, `WORD_COUNT`=2: second address wraps to 24'h000000; `oPass`=1.
- Wrong-bit `iDone[0]` during a write plus `iStart` while busy: both are ignored and `oCall` stays 2'b10. `RESET` mid-read gives all outputs 0 on the next cycle.
- With `SDRAM_SELFTEST_LFSR_EN`: the first write data is 64'h0123_4567_89AB_CDEF, and read compares pass.

Source files
------------

// File: rtl/sdram_selftest_ctrl.sv
// Self-test master for the SDRAM base module: writes a pattern over a range of words, reads it back and reports.
// Define SDRAM_SELFTEST_LFSR_EN to use a 64-bit LFSR pattern instead of the address-derived one.
module sdram_selftest_ctrl #(
    parameter logic [23:0] ADDR_START = 24'h000000,
    parameter int unsigned WORD_COUNT = 256,
    parameter int unsigned ADDR_STEP  = 4,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        iStart,
    output logic        oBusy,
    output logic        oPass,
    output logic        oFail,
    output logic        oTimeout,
    output logic [15:0] oErrCount,
    output logic [23:0] oFirstErrAddr,
    output logic [1:0]  oCall,
    input  logic [1:0]  iDone,
    output logic [23:0] oAddr,
    output logic [63:0] oData,
    input  logic [63:0] iData
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WR_NEXT, S_RD_INIT, S_READ, S_CHECK, S_FINISH
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
    localparam logic [23:0] STEP     = 24'(ADDR_STEP);
    localparam logic [1:0]  CALL_WR  = 2'b10;
    localparam logic [1:0]  CALL_RD  = 2'b01;

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] idx_q, idx_d;
    logic [63:0] pat_q, pat_d;
    logic [63:0] rdata_q, rdata_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [23:0] first_err_q, first_err_d;
    logic        timeout_q, timeout_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        busy_q, busy_d;
    logic [1:0]  call_q, call_d;

    logic [23:0] addr_next;
    logic [63:0] pat_init;
    logic [63:0] pat_adv;
    logic        mismatch;

`ifdef SDRAM_SELFTEST_LFSR_EN
    localparam logic [63:0] LFSR_SEED = 64'h0123_4567_89AB_CDEF;
`else
    function automatic logic [63:0] addr_pattern(input logic [23:0] a);
        return {8'hA5, a, 8'h5A, ~a};
    endfunction
`endif

    // Pattern for the first word of a pass and for the word after the current one.
    always_comb begin
        addr_next = addr_q + STEP;
`ifdef SDRAM_SELFTEST_LFSR_EN
        pat_init = LFSR_SEED;
        pat_adv  = {pat_q[62:0], pat_q[63] ^ pat_q[62] ^ pat_q[60] ^ pat_q[59]};
`else
        pat_init = addr_pattern(ADDR_START);
        pat_adv  = addr_pattern(addr_next);
`endif
    end

    assign mismatch = (rdata_q != pat_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        pat_d       = pat_q;
        rdata_d     = rdata_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        timeout_d   = timeout_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        busy_d      = busy_q;
        call_d      = 2'b00;

        case (state_q)
            S_IDLE, S_FINISH: begin
                if (iStart) begin
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    timeout_d   = 1'b0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    busy_d      = 1'b1;
                    addr_d      = ADDR_START;
                    idx_d       = '0;
                    pat_d       = pat_init;
                    tmo_cnt_d   = '0;
                    call_d      = CALL_WR;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE, S_READ: begin
                call_d = (state_q == S_WRITE) ? CALL_WR : CALL_RD;
                // A done pulse beats a timeout landing in the same cycle.
                if (state_q == S_WRITE && iDone[1]) begin
                    call_d  = 2'b00;
                    state_d = S_WR_NEXT;
                end else if (state_q == S_READ && iDone[0]) begin
                    call_d  = 2'b00;
                    rdata_d = iData;
                    state_d = S_CHECK;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    call_d    = 2'b00;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end
            S_WR_NEXT: begin
                addr_d = addr_next;
                idx_d  = idx_q + 16'd1;
                pat_d  = pat_adv;
                if (idx_q == LAST_IDX) begin
                    state_d = S_RD_INIT;
                end else begin
                    tmo_cnt_d = '0;
                    call_d    = CALL_WR;
                    state_d   = S_WRITE;
                end
            end
            S_RD_INIT: begin
                addr_d    = ADDR_START;
                idx_d     = '0;
                pat_d     = pat_init;
                tmo_cnt_d = '0;
                call_d    = CALL_RD;
                state_d   = S_READ;
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                    if (err_cnt_q == 16'd0) first_err_d = addr_q;
                end
                addr_d = addr_next;
                idx_d  = idx_q + 16'd1;
                pat_d  = pat_adv;
                if (idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    pass_d  = !mismatch && (err_cnt_q == 16'd0) && !timeout_q;
                    fail_d  = !pass_d;
                    state_d = S_FINISH;
                end else begin
                    tmo_cnt_d = '0;
                    call_d    = CALL_RD;
                    state_d   = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            idx_q       <= '0;
            pat_q       <= '0;
            rdata_q     <= '0;
            tmo_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            timeout_q   <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            busy_q      <= 1'b0;
            call_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            pat_q       <= pat_d;
            rdata_q     <= rdata_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            timeout_q   <= timeout_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            busy_q      <= busy_d;
            call_q      <= call_d;
        end
    end

    assign oBusy         = busy_q;
    assign oPass         = pass_q;
    assign oFail         = fail_q;
    assign oTimeout      = timeout_q;
    assign oErrCount     = err_cnt_q;
    assign oFirstErrAddr = first_err_q;
    assign oCall         = call_q;
    assign oAddr         = addr_q;
    assign oData         = pat_q;

endmodule
